mult: RTL and testbench
=======================

MULT -- requirements
Module: mult

Interface
REQ-001 The block SHALL have the port: Clock  input  1  single clock; all state updates on rising edge.
REQ-002 The block SHALL have the port: Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clock.
REQ-003 The block SHALL have the port: multiplicand  input  32  signed two's-complement operand M.
REQ-004 The block SHALL have the port: multiplier  input  32  signed two's-complement operand Q.
REQ-005 The block SHALL have the port: Start  input  1  request from control unit; sampled only in IDLE.
REQ-006 The block SHALL have the port: product_hi  output  32  upper 32 bits of 64-bit signed product (registered).
REQ-007 The block SHALL have the port: product_lo  output  32  lower 32 bits of 64-bit signed product (registered).
REQ-008 The block SHALL have the port: MultToControl  output  1  one-cycle completion pulse to control unit.
REQ-009 The block SHALL have the port: Busy  output  1  high while in RUN or DONE.

Function
REQ-010 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE with Start=1 at a rising edge, the block SHALL load A=33'b0, Q=multiplier, Q_1=0, M=multiplicand sign-extended to 33 bits, count=0, and go to RUN.
REQ-012 In IDLE with Start=0, all registers SHALL hold.
REQ-013 In RUN, each rising edge SHALL perform one radix-2 Booth step on {Q[0],Q_1}: 10 -> A=A-M; 01 -> A=A+M; 00/11 -> A unchanged; all arithmetic is 33-bit two's complement.
REQ-014 After the add/subtract in the same edge, {A,Q,Q_1} SHALL be arithmetically shifted right by one (A[32] replicated), and count SHALL be incremented.
REQ-015 The step taken with count=31 SHALL be the last; the FSM SHALL then go to DONE (exactly 32 RUN edges).
REQ-016 In DONE, at the next rising edge, the block SHALL set product_hi=A[31:0], product_lo=Q, MultToControl=1, and return to IDLE.
REQ-017 MultToControl SHALL be high for exactly one cycle, cleared at the following rising edge.
REQ-018 Latency: with Start sampled at edge 1, results and MultToControl SHALL appear after edge 34.
REQ-019 product_hi/product_lo SHALL hold their last result until the next DONE update, and SHALL NOT change during RUN.
REQ-020 Start SHALL be ignored while Busy=1; operand changes after the Start edge SHALL NOT affect the result.
REQ-021 If Start=1 in the same cycle MultToControl=1 (FSM in IDLE), a new operation SHALL begin at that edge.
REQ-022 The result SHALL be the exact 64-bit signed product for all operand pairs, including M=Q=0x80000000 (33-bit A prevents overflow).
REQ-023 Busy SHALL be combinationally decoded from the FSM state (RUN or DONE).

Reset
REQ-024 When Reset=0, the block SHALL force state=IDLE, product_hi=0, product_lo=0, MultToControl=0, A=0, Q=0, Q_1=0, M=0, and count=0.
REQ-025 Reset asserted mid-operation SHALL abort the operation with no MultToControl pulse; after release, the block SHALL wait in IDLE for Start.
REQ-026 The first rising edge after Reset release SHALL be able to sample Start.

Verification
REQ-027 Test: M=3, Q=4, Start pulsed one cycle -> after edge 34: product_hi=0x00000000, product_lo=0x0000000C, MultToControl high for one cycle, Busy high for edges 1-34.
REQ-028 Test: M=0xFFFFFFFF, Q=0xFFFFFFFF -> product_hi=0x00000000, product_lo=0x00000001.
REQ-029 Test: M=0x80000000, Q=0x80000000 -> product_hi=0x40000000, product_lo=0x00000000.
REQ-030 Test: M=0x7FFFFFFF, Q=0xFFFFFFFF -> product_hi=0xFFFFFFFF, product_lo=0x80000001; Start re-pulsed and operands changed at edge 10 -> no effect on the result or timing.
REQ-031 Test: start 5*6, assert Reset=0 at edge 15 -> outputs 0 immediately, no MultToControl pulse; after release, start 5*6 -> product_lo=0x1E after 34 edges.
REQ-032 Test: Start held high continuously with M=2, Q=-3 -> back-to-back results 0xFFFFFFFF/0xFFFFFFFA every 34 cycles, one MultToControl pulse per result.

Source files
------------

// File: rtl/mult_if.sv
// Operand/result handshake between the control unit and the Booth multiplier.
interface mult_if;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        Start;
    logic [31:0] product_hi;
    logic [31:0] product_lo;
    logic        MultToControl;
    logic        Busy;

    modport master (
        output multiplicand, multiplier, Start,
        input  product_hi, product_lo, MultToControl, Busy
    );

    modport slave (
        input  multiplicand, multiplier, Start,
        output product_hi, product_lo, MultToControl, Busy
    );
endinterface

// File: rtl/mult.sv
// Sequential radix-2 Booth multiplier: 32x32 signed -> 64-bit product in 34 cycles
// (1 load edge, 32 Booth steps, 1 result edge).
module mult (
    input  logic  Clock,
    input  logic  Reset,
    mult_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [32:0] a;
    logic [31:0] q;
    logic        q_1;
    logic [32:0] m;
    logic [4:0]  count;
    logic [32:0] sum;

    // A is 33 bits wide so that A - M cannot overflow when M = -2^31.
    always_comb begin
        // NOTE: default first so every path assigns sum and no latch is inferred.
        sum = a;
        case ({q[0], q_1})
            2'b10:   sum = a - m;
            2'b01:   sum = a + m;
            default: sum = a;
        endcase
    end

    assign bus.Busy = (state == RUN) || (state == DONE);

    // NOTE: all state below uses non-blocking assignments so every register
    // sees the pre-edge values of the others, as the Booth shift requires.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state             <= IDLE;
            a                 <= '0;
            q                 <= '0;
            q_1               <= 1'b0;
            m                 <= '0;
            count             <= '0;
            bus.product_hi    <= '0;
            bus.product_lo    <= '0;
            bus.MultToControl <= 1'b0;
        end else begin
            bus.MultToControl <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Start) begin
                        a     <= '0;
                        q     <= bus.multiplier;
                        q_1   <= 1'b0;
                        m     <= {bus.multiplicand[31], bus.multiplicand};
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Arithmetic right shift of {sum, q, q_1}, replicating the sign of sum.
                    a     <= {sum[32], sum[32:1]};
                    q     <= {sum[0], q[31:1]};
                    q_1   <= q[0];
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    bus.product_hi    <= a[31:0];
                    bus.product_lo    <= q;
                    bus.MultToControl <= 1'b1;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult.sv
// Directed self-checking bench for the Booth multiplier: reset, signed corner
// products, Start-while-busy, mid-operation reset and back-to-back operation.
module tb_mult;

    logic Clock;
    logic Reset;
    int   compared;
    int   mismatched;

    mult_if bus ();

    mult dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Start on the next edge (edge 1), then check timing and result at edge 34.
    task automatic do_op(input string tag, input logic [31:0] mv, input logic [31:0] qv,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        logic [31:0] prev_hi;
        prev_hi              = bus.product_hi;
        bus.multiplicand     = mv;
        bus.multiplier       = qv;
        bus.Start            = 1'b1;
        tick(1);
        bus.Start            = 1'b0;
        check({tag, "_busy_e1"}, {31'd0, bus.Busy}, 32'd1);
        tick(32);
        check({tag, "_busy_e33"}, {31'd0, bus.Busy}, 32'd1);
        check({tag, "_pulse_e33"}, {31'd0, bus.MultToControl}, 32'd0);
        check({tag, "_hi_hold_e33"}, bus.product_hi, prev_hi);
        tick(1);
        check({tag, "_hi"}, bus.product_hi, exp_hi);
        check({tag, "_lo"}, bus.product_lo, exp_lo);
        check({tag, "_pulse_e34"}, {31'd0, bus.MultToControl}, 32'd1);
        check({tag, "_busy_e34"}, {31'd0, bus.Busy}, 32'd0);
        tick(1);
        check({tag, "_pulse_e35"}, {31'd0, bus.MultToControl}, 32'd0);
    endtask

    initial begin
        logic saw_pulse;
        compared         = 0;
        mismatched       = 0;
        Reset            = 1'b1;
        bus.Start        = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier   = '0;

        // Asynchronous reset before any clock edge.
        #2 Reset = 1'b0;
        #1;
        check("rst_hi", bus.product_hi, 32'h0);
        check("rst_lo", bus.product_lo, 32'h0);
        check("rst_pulse", {31'd0, bus.MultToControl}, 32'd0);
        check("rst_busy", {31'd0, bus.Busy}, 32'd0);
        tick(2);
        Reset = 1'b1;

        // First edge after release samples Start.
        do_op("m3q4", 32'd3, 32'd4, 32'h0000_0000, 32'h0000_000C);
        do_op("neg1sq", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        do_op("minsq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // Start re-pulsed and operands changed at edge 10 must not disturb the result.
        bus.multiplicand = 32'h7FFF_FFFF;
        bus.multiplier   = 32'hFFFF_FFFF;
        bus.Start        = 1'b1;
        tick(1);
        bus.Start        = 1'b0;
        tick(8);
        bus.Start        = 1'b1;
        bus.multiplicand = 32'd7;
        bus.multiplier   = 32'd9;
        tick(1);
        bus.Start        = 1'b0;
        tick(23);
        check("busy_e33_restart", {31'd0, bus.Busy}, 32'd1);
        check("pulse_e33_restart", {31'd0, bus.MultToControl}, 32'd0);
        tick(1);
        check("maxneg1_hi", bus.product_hi, 32'hFFFF_FFFF);
        check("maxneg1_lo", bus.product_lo, 32'h8000_0001);
        check("maxneg1_pulse", {31'd0, bus.MultToControl}, 32'd1);
        tick(1);
        check("maxneg1_idle", {31'd0, bus.Busy}, 32'd0);

        // Reset at edge 15 of a 5*6 operation aborts it with no pulse.
        bus.multiplicand = 32'd5;
        bus.multiplier   = 32'd6;
        bus.Start        = 1'b1;
        tick(1);
        bus.Start        = 1'b0;
        tick(13);
        #2 Reset = 1'b0;
        #1;
        check("abort_hi", bus.product_hi, 32'h0);
        check("abort_lo", bus.product_lo, 32'h0);
        check("abort_busy", {31'd0, bus.Busy}, 32'd0);
        tick(2);
        Reset     = 1'b1;
        saw_pulse = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            saw_pulse = saw_pulse | bus.MultToControl;
        end
        check("abort_no_pulse", {31'd0, saw_pulse}, 32'd0);
        check("abort_idle", {31'd0, bus.Busy}, 32'd0);
        do_op("m5q6", 32'd5, 32'd6, 32'h0000_0000, 32'h0000_001E);

        // Start held high: back-to-back results every 34 cycles.
        bus.multiplicand = 32'd2;
        bus.multiplier   = 32'hFFFF_FFFD;
        bus.Start        = 1'b1;
        tick(34);
        check("b2b1_hi", bus.product_hi, 32'hFFFF_FFFF);
        check("b2b1_lo", bus.product_lo, 32'hFFFF_FFFA);
        check("b2b1_pulse", {31'd0, bus.MultToControl}, 32'd1);
        tick(1);
        check("b2b_restart_busy", {31'd0, bus.Busy}, 32'd1);
        check("b2b_restart_pulse", {31'd0, bus.MultToControl}, 32'd0);
        saw_pulse = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            saw_pulse = saw_pulse | bus.MultToControl;
        end
        check("b2b_gap_no_pulse", {31'd0, saw_pulse}, 32'd0);
        tick(1);
        check("b2b2_hi", bus.product_hi, 32'hFFFF_FFFF);
        check("b2b2_lo", bus.product_lo, 32'hFFFF_FFFA);
        check("b2b2_pulse", {31'd0, bus.MultToControl}, 32'd1);
        bus.Start = 1'b0;
        tick(1);
        check("b2b_end_pulse", {31'd0, bus.MultToControl}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
